cam_stream_tx: RTL and testbench



---
 rtl/cam_tx_pkg.sv | 24 ++
 rtl/cam_tx_pclk_gen.sv | 37 +++
 rtl/cam_stream_tx.sv | 216 +++++++++++++++++++++
 tb/tb_cam_stream_tx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_tx_pkg.sv
// Shared types and constants for the camera-bus transmitter: FSM states, counter width, byte order.
package cam_tx_pkg;

    localparam int CNT_W         = 16;
    localparam bit HI_BYTE_FIRST = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_HBLANK,
        ST_VFRONT
    } state_t;

    function automatic logic [7:0] first_byte(input logic [15:0] px);
        return HI_BYTE_FIRST ? px[15:8] : px[7:0];
    endfunction

    function automatic logic [7:0] second_byte(input logic [15:0] px);
        return HI_BYTE_FIRST ? px[7:0] : px[15:8];
    endfunction

endpackage

// File: rtl/cam_tx_pclk_gen.sv
// Pixel-clock divider: cam_pclk low then high for PCLK_DIV/2 clks each; fall_strobe_o is high in the
// clk cycle whose closing edge drops pclk, so every output register moves together with that edge.
module cam_tx_pclk_gen #(
    parameter int PCLK_DIV = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic pclk_o,
    output logic fall_strobe_o
);
    import cam_tx_pkg::*;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(PCLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF     = CNT_W'(PCLK_DIV / 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pclk_q, pclk_d;

    always_comb begin
        cnt_d  = (cnt_q == DIV_LAST) ? '0 : cnt_q + CNT_W'(1);
        pclk_d = (cnt_d >= HALF);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            pclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pclk_q <= pclk_d;
        end
    end

    assign pclk_o        = pclk_q;
    assign fall_strobe_o = (cnt_q == DIV_LAST);

endmodule

// File: rtl/cam_stream_tx.sv
// DVP transmitter: 16-bit ready/valid/sync pixels in, pclk/vsync/href/byte out, outputs move on pclk falls.
// One-pixel buffer, img_ready registered (= buffer empty). Optional CAM_TX_TEST_PATTERN_EN adds pattern_en.
module cam_stream_tx #(
    parameter int PCLK_DIV    = 2,
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_ACTIVE    = 480,
    parameter int V_FRONT     = 10
) (
    input  logic        clk,
    input  logic        reset,
    output logic        img_ready,
    input  logic        img_valid,
    input  logic        img_sync,
    input  logic [15:0] img_data,
`ifdef CAM_TX_TEST_PATTERN_EN
    input  logic        pattern_en,
`endif
    output logic        cam_pclk,
    output logic        cam_vsync,
    output logic        cam_hsync,
    output logic [7:0]  cam_data,
    output logic        frame_active,
    output logic        err_underflow,
    output logic        err_resync
);
    import cam_tx_pkg::*;

    localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(2 * H_ACTIVE + H_BLANK - 1);
    localparam logic [CNT_W-1:0] ACT_LAST  = CNT_W'(2 * H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] HB_LAST   = CNT_W'(H_BLANK - 1);
    localparam logic [CNT_W-1:0] VS_LAST   = CNT_W'(VSYNC_LINES - 1);
    localparam logic [CNT_W-1:0] VB_LAST   = CNT_W'(V_BACK - 1);
    localparam logic [CNT_W-1:0] VA_LAST   = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] VF_LAST   = CNT_W'(V_FRONT - 1);

    logic fall_strobe;
    logic pat_on;

`ifdef CAM_TX_TEST_PATTERN_EN
    assign pat_on = pattern_en;
`else
    assign pat_on = 1'b0;
`endif

    cam_tx_pclk_gen #(.PCLK_DIV(PCLK_DIV)) u_pclk (
        .clk_i         (clk),
        .reset_i       (reset),
        .pclk_o        (cam_pclk),
        .fall_strobe_o (fall_strobe)
    );

    state_t           state_q, state_d, cur_state, blank_next;
    logic [CNT_W-1:0] h_q, h_d, v_q, v_d, cur_h, cur_v, blank_last;
    logic             buf_vld_q, buf_vld_d, rdy_q, rdy_d, pend_q, pend_d;
    logic [15:0]      buf_dat_q, buf_dat_d;
    logic [7:0]       lo_q, lo_d, dat_q, dat_d;
    logic             vs_q, vs_d, hs_q, hs_d, fa_q, fa_d, unf_q, unf_d, rsy_q, rsy_d;
    logic             accept, idle;

    always_comb begin
        accept    = img_valid && rdy_q;
        idle      = (state_q == ST_IDLE) && !pend_q;
        // A pending resync turns the next emitted slot into the first VSYNC slot of a new frame.
        cur_state = pend_q ? ST_VSYNC : state_q;
        cur_h     = pend_q ? '0 : h_q;
        cur_v     = pend_q ? '0 : v_q;

        case (cur_state)
            ST_VSYNC: begin blank_last = VS_LAST; blank_next = ST_VBACK;  end
            ST_VBACK: begin blank_last = VB_LAST; blank_next = ST_ACTIVE; end
            default:  begin blank_last = VF_LAST; blank_next = ST_IDLE;   end
        endcase

        state_d   = state_q;
        h_d       = h_q;
        v_d       = v_q;
        buf_vld_d = buf_vld_q;
        buf_dat_d = buf_dat_q;
        lo_d      = lo_q;
        pend_d    = pend_q;
        vs_d      = vs_q;
        hs_d      = hs_q;
        dat_d     = dat_q;
        fa_d      = fa_q;
        unf_d     = unf_q;
        rsy_d     = 1'b0;

        if (fall_strobe) begin
            pend_d  = 1'b0;
            vs_d    = 1'b0;
            hs_d    = 1'b0;
            dat_d   = 8'h00;
            fa_d    = (cur_state != ST_IDLE);
            state_d = cur_state;
            h_d     = cur_h + CNT_W'(1);
            v_d     = cur_v;
            case (cur_state)
                ST_VSYNC, ST_VBACK, ST_VFRONT: begin
                    vs_d = (cur_state == ST_VSYNC);
                    if (cur_h == LINE_LAST) begin
                        h_d = '0;
                        if (cur_v == blank_last) begin
                            v_d     = '0;
                            state_d = blank_next;
                        end else begin
                            v_d = cur_v + CNT_W'(1);
                        end
                    end
                end
                ST_ACTIVE: begin
                    hs_d = 1'b1;
                    if (!cur_h[0]) begin
                        if (pat_on) begin
                            dat_d = cur_v[7:0];
                            lo_d  = cur_h[8:1];
                        end else if (buf_vld_q) begin
                            dat_d     = first_byte(buf_dat_q);
                            lo_d      = second_byte(buf_dat_q);
                            buf_vld_d = 1'b0;
                        end else begin
                            lo_d  = 8'h00;
                            unf_d = 1'b1;
                        end
                    end else begin
                        dat_d = lo_q;
                    end
                    if (cur_h == ACT_LAST) begin
                        h_d     = '0;
                        state_d = ST_HBLANK;
                    end
                end
                ST_HBLANK: begin
                    if (cur_h == HB_LAST) begin
                        h_d = '0;
                        if (cur_v == VA_LAST) begin
                            v_d     = '0;
                            state_d = ST_VFRONT;
                        end else begin
                            v_d     = cur_v + CNT_W'(1);
                            state_d = ST_ACTIVE;
                        end
                    end
                end
                default: h_d = '0;
            endcase
        end

        if (idle) begin
            buf_vld_d = 1'b0;
            if (pat_on || (accept && img_sync)) begin
                buf_vld_d = !pat_on;
                buf_dat_d = img_data;
                state_d   = ST_VSYNC;
                h_d       = '0;
                v_d       = '0;
                unf_d     = 1'b0;
            end
        end else if (accept) begin
            buf_vld_d = 1'b1;
            buf_dat_d = img_data;
            if (img_sync) begin
                rsy_d  = 1'b1;
                pend_d = 1'b1;
                unf_d  = 1'b0;
            end
        end

        rdy_d = !pat_on && (((state_d == ST_IDLE) && !pend_d) || !buf_vld_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            h_q       <= '0;
            v_q       <= '0;
            buf_vld_q <= 1'b0;
            buf_dat_q <= '0;
            lo_q      <= '0;
            rdy_q     <= 1'b0;
            pend_q    <= 1'b0;
            vs_q      <= 1'b0;
            hs_q      <= 1'b0;
            dat_q     <= '0;
            fa_q      <= 1'b0;
            unf_q     <= 1'b0;
            rsy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            v_q       <= v_d;
            buf_vld_q <= buf_vld_d;
            buf_dat_q <= buf_dat_d;
            lo_q      <= lo_d;
            rdy_q     <= rdy_d;
            pend_q    <= pend_d;
            vs_q      <= vs_d;
            hs_q      <= hs_d;
            dat_q     <= dat_d;
            fa_q      <= fa_d;
            unf_q     <= unf_d;
            rsy_q     <= rsy_d;
        end
    end

    assign img_ready     = rdy_q;
    assign cam_vsync     = vs_q;
    assign cam_hsync     = hs_q;
    assign cam_data      = dat_q;
    assign frame_active  = fa_q;
    assign err_underflow = unf_q;
    assign err_resync    = rsy_q;

endmodule

// File: tb/tb_cam_stream_tx.sv
// Directed bench for cam_stream_tx with a small frame (line = 10 pclks, frame = 50 pclks).
module tb_cam_stream_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        img_ready;
    logic        img_valid = 1'b0;
    logic        img_sync = 1'b0;
    logic [15:0] img_data = 16'h0000;
    logic        cam_pclk, cam_vsync, cam_hsync;
    logic [7:0]  cam_data;
    logic        frame_active, err_underflow, err_resync;
`ifdef CAM_TX_TEST_PATTERN_EN
    logic        pattern_en = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cam_stream_tx #(
        .PCLK_DIV(2), .H_ACTIVE(4), .H_BLANK(2), .VSYNC_LINES(1),
        .V_BACK(1), .V_ACTIVE(2), .V_FRONT(1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .img_ready     (img_ready),
        .img_valid     (img_valid),
        .img_sync      (img_sync),
        .img_data      (img_data),
`ifdef CAM_TX_TEST_PATTERN_EN
        .pattern_en    (pattern_en),
`endif
        .cam_pclk      (cam_pclk),
        .cam_vsync     (cam_vsync),
        .cam_hsync     (cam_hsync),
        .cam_data      (cam_data),
        .frame_active  (frame_active),
        .err_underflow (err_underflow),
        .err_resync    (err_resync)
    );

    // Receiver view: {frame_active, vsync, hsync, data} captured on every pclk rising edge.
    logic [10:0] smp_q[$];
    always @(posedge cam_pclk) smp_q.push_back({frame_active, cam_vsync, cam_hsync, cam_data});

    typedef struct {
        int          off;
        logic [10:0] exp;
    } vec_t;
    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input int off, input logic fa, input logic vs, input logic hs, input logic [7:0] d);
        vec_t v;
        v.off = off;
        v.exp = {fa, vs, hs, d};
        tv.push_back(v);
    endtask

    task automatic push(input string name, input logic [15:0] d, input logic s);
        int waits;
        img_valid = 1'b1;
        img_data  = d;
        img_sync  = s;
        waits     = 0;
        while (!img_ready && waits < 400) begin
            @(negedge clk);
            waits++;
        end
        chk({name, "_ready"}, 32'(img_ready), 1);
        @(negedge clk);
        img_valid = 1'b0;
        img_sync  = 1'b0;
    endtask

    task automatic run_table(input string tag, input int base, output int v0);
        int need;
        v0   = -1;
        need = 0;
        for (int i = base; i < smp_q.size(); i++)
            if (v0 < 0 && smp_q[i][9]) v0 = i;
        chk({tag, "_vsync_seen"}, 32'(v0 >= 0), 1);
        if (v0 >= 0) begin
            foreach (tv[j]) if (tv[j].off >= need) need = tv[j].off + 1;
            chk({tag, "_len"}, 32'(smp_q.size() >= v0 + need), 1);
            if (smp_q.size() >= v0 + need)
                foreach (tv[j])
                    chk($sformatf("%s_k%0d", tag, tv[j].off), 32'(smp_q[v0 + tv[j].off]), 32'(tv[j].exp));
        end
    endtask

    function automatic int count_vsync(input int base);
        int n = 0;
        for (int i = base; i < smp_q.size(); i++) n += int'(smp_q[i][9]);
        return n;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: run still active, expected it to finish");
        $fatal(1);
    end

    initial begin
        int base, v0, vs_n, hs_n, lat;

        // Reset values
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({cam_pclk, cam_vsync, cam_hsync, cam_data, img_ready,
                                   frame_active, err_underflow, err_resync}), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(img_ready), 1);

        // Non-sync pixels in IDLE are all swallowed and start nothing
        base = smp_q.size();
        for (int i = 0; i < 4; i++) push($sformatf("idle_px%0d", i), 16'hA000 + 16'(i), 1'b0);
        chk("idle_ready_held", 32'(img_ready), 1);
        repeat (20) @(negedge clk);
        chk("idle_no_vsync", 32'(count_vsync(base)), 0);
        chk("idle_no_frame", 32'(frame_active), 0);

        // Continuous 8-pixel frame
        tv.delete();
        add(0, 1, 1, 0, 8'h00);  add(9, 1, 1, 0, 8'h00);
        add(10, 1, 0, 0, 8'h00); add(19, 1, 0, 0, 8'h00);
        add(20, 1, 0, 1, 8'h01); add(21, 1, 0, 1, 8'h02);
        add(22, 1, 0, 1, 8'h03); add(27, 1, 0, 1, 8'h08);
        add(28, 1, 0, 0, 8'h00); add(29, 1, 0, 0, 8'h00);
        add(30, 1, 0, 1, 8'h09); add(37, 1, 0, 1, 8'h10);
        add(38, 1, 0, 0, 8'h00); add(40, 1, 0, 0, 8'h00);
        add(49, 1, 0, 0, 8'h00); add(50, 0, 0, 0, 8'h00);
        base = smp_q.size();
        push("f1_px0", 16'h0102, 1'b1);
        lat = 0;
        while (!cam_vsync && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("f1_vsync_latency_le2", 32'(lat >= 1 && lat <= 2), 1);
        for (int i = 1; i < 8; i++) push($sformatf("f1_px%0d", i), {8'(2 * i + 1), 8'(2 * i + 2)}, 1'b0);
        repeat (60) @(negedge clk);
        run_table("f1", base, v0);
        if (v0 >= 0 && smp_q.size() >= v0 + 50) begin
            vs_n = 0;
            hs_n = 0;
            for (int k = 0; k < 50; k++) begin
                vs_n += int'(smp_q[v0 + k][9]);
                hs_n += int'(smp_q[v0 + k][8]);
            end
            chk("f1_vsync_pclks", 32'(vs_n), 10);
            chk("f1_hsync_pclks", 32'(hs_n), 16);
        end
        chk("f1_no_underflow", 32'(err_underflow), 0);

        // Third pixel missing -> 00,00 in its slot and a sticky underflow flag
        tv.delete();
        add(20, 1, 0, 1, 8'h01); add(21, 1, 0, 1, 8'h02);
        add(22, 1, 0, 1, 8'h03); add(23, 1, 0, 1, 8'h04);
        add(24, 1, 0, 1, 8'h00); add(25, 1, 0, 1, 8'h00);
        add(26, 1, 0, 1, 8'h05); add(27, 1, 0, 1, 8'h06);
        add(30, 1, 0, 1, 8'h07); add(37, 1, 0, 1, 8'h0E);
        base = smp_q.size();
        push("u_px0", 16'h0102, 1'b1);
        push("u_px1", 16'h0304, 1'b0);
        lat = 0;
        while (!img_ready && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("u_buffer_drained", 32'(img_ready), 1);
        chk("u_flag_clear_before_gap", 32'(err_underflow), 0);
        repeat (4) @(negedge clk);
        for (int i = 2; i < 7; i++) push($sformatf("u_px%0d", i), {8'(2 * i + 1), 8'(2 * i + 2)}, 1'b0);
        repeat (60) @(negedge clk);
        run_table("u", base, v0);
        chk("u_flag_sticky", 32'(err_underflow), 1);

        // Sync on the 5th pixel -> resync pulse, forced new frame carrying that pixel
        push("r_px0", 16'h0102, 1'b1);
        chk("r_underflow_cleared", 32'(err_underflow), 0);
        for (int i = 1; i < 4; i++) push($sformatf("r_px%0d", i), {8'(2 * i + 1), 8'(2 * i + 2)}, 1'b0);
        base = smp_q.size();
        push("r_px4", 16'h090A, 1'b1);
        chk("r_resync_pulse", 32'(err_resync), 1);
        @(negedge clk);
        chk("r_resync_one_cycle", 32'(err_resync), 0);
        chk("r_vsync_forced", 32'({cam_vsync, cam_hsync}), 32'b10);
        tv.delete();
        add(0, 1, 1, 0, 8'h00);
        add(20, 1, 0, 1, 8'h09); add(21, 1, 0, 1, 8'h0A);
        add(22, 1, 0, 1, 8'h00);
        repeat (130) @(negedge clk);
        run_table("r", base, v0);
        chk("r_underflow_after", 32'(err_underflow), 1);

        // Reset in the middle of an active line
        push("x_px0", 16'h0102, 1'b1);
        push("x_px1", 16'h0304, 1'b0);
        lat = 0;
        while (!cam_hsync && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("x_in_line", 32'(cam_hsync), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("x_reset_outputs", 32'({cam_pclk, cam_vsync, cam_hsync, cam_data, img_ready,
                                     frame_active, err_underflow, err_resync}), 0);
        reset = 1'b0;
        base  = smp_q.size();
        @(negedge clk);
        chk("x_ready_after_reset", 32'(img_ready), 1);
        repeat (120) @(negedge clk);
        chk("x_no_restart", 32'(count_vsync(base)), 0);
        chk("x_frame_idle", 32'(frame_active), 0);

`ifdef CAM_TX_TEST_PATTERN_EN
        // Free-running test pattern: pixel = {line, col}
        tv.delete();
        add(20, 1, 0, 1, 8'h00); add(21, 1, 0, 1, 8'h00);
        add(22, 1, 0, 1, 8'h00); add(23, 1, 0, 1, 8'h01);
        add(34, 1, 0, 1, 8'h01); add(35, 1, 0, 1, 8'h02);
        base       = smp_q.size();
        pattern_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("p_ready_low", 32'(img_ready), 0);
        repeat (150) @(negedge clk);
        run_table("p", base, v0);
        chk("p_ready_still_low", 32'(img_ready), 0);
        chk("p_no_underflow", 32'(err_underflow), 0);
        pattern_en = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
